wr_req_arb: RTL and testbench

- Two-requester arbiter and scheduler for the single cache-line write-request channel (wr_req_*) toward the CCI interface.
- Grants one full-line write per cycle using round-robin, and tags mdata with the requester ID.
- Routes both write-response lanes back to their owners.
- Enforces a per-requester outstanding-write credit limit and reports drain status.

---
 rtl/wr_req_arb.sv | 141 ++++++++++++++
 tb/tb_wr_req_arb.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_req_arb.sv
// Round-robin arbiter for the line-write channel: tags mdata with the requester ID, routes responses, enforces credits.
// Accept -> wr_req_en and response -> X_rsp_valid each take 1 registered cycle; almostfull or exhausted credit withholds ack.
module wr_req_arb #(
    parameter int ADDR_LMT    = 20,
    parameter int MDATA       = 14,
    parameter int CACHE_WIDTH = 512,
    parameter int MAX_OUT     = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   a_req_valid,
    input  logic [ADDR_LMT-1:0]    a_req_addr,
    input  logic [MDATA-2:0]       a_req_mdata,
    input  logic [CACHE_WIDTH-1:0] a_req_data,
    output logic                   a_req_ack,
    output logic [1:0]             a_rsp_valid,
    output logic [MDATA-2:0]       a_rsp_mdata0,
    output logic [MDATA-2:0]       a_rsp_mdata1,
    input  logic                   b_req_valid,
    input  logic [ADDR_LMT-1:0]    b_req_addr,
    input  logic [MDATA-2:0]       b_req_mdata,
    input  logic [CACHE_WIDTH-1:0] b_req_data,
    output logic                   b_req_ack,
    output logic [1:0]             b_rsp_valid,
    output logic [MDATA-2:0]       b_rsp_mdata0,
    output logic [MDATA-2:0]       b_rsp_mdata1,
    output logic [ADDR_LMT-1:0]    wr_req_addr,
    output logic [MDATA-1:0]       wr_req_mdata,
    output logic [CACHE_WIDTH-1:0] wr_req_data,
    output logic                   wr_req_en,
    input  logic                   wr_req_almostfull,
    input  logic                   wr_rsp0_valid,
    input  logic                   wr_rsp1_valid,
    input  logic [MDATA-1:0]       wr_rsp0_mdata,
    input  logic [MDATA-1:0]       wr_rsp1_mdata,
    output logic                   drained
);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_OUT);
    typedef logic [CW+1:0] wide_t;

    logic [CW-1:0]          cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic                   last_q;
    logic                   elig_a, elig_b, gnt_a, gnt_b;
    logic [1:0]             rsp_a, rsp_b;
    logic                   wr_en_q;
    logic [ADDR_LMT-1:0]    wr_addr_q;
    logic [MDATA-1:0]       wr_mdata_q;
    logic [CACHE_WIDTH-1:0] wr_data_q;
    logic [1:0]             a_rsp_vld_q, b_rsp_vld_q;
    logic [MDATA-2:0]       a_md0_q, a_md1_q, b_md0_q, b_md1_q;
    logic                   drained_q;

    // Responses in excess of the outstanding count are a protocol error; clamp instead of wrapping.
    function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] c, input logic inc,
                                               input logic [1:0] lanes);
        wide_t up, dn;
        up = wide_t'(c) + wide_t'(inc);
        dn = wide_t'(lanes[0]) + wide_t'(lanes[1]);
        return (dn > up) ? '0 : CW'(up - dn);
    endfunction

    always_comb begin
        elig_a  = reset_n && a_req_valid && (cnt_a_q < CMAX) && !wr_req_almostfull;
        elig_b  = reset_n && b_req_valid && (cnt_b_q < CMAX) && !wr_req_almostfull;
        gnt_a   = elig_a && (!elig_b || last_q);
        gnt_b   = elig_b && (!elig_a || !last_q);
        rsp_a   = {wr_rsp1_valid && !wr_rsp1_mdata[MDATA-1], wr_rsp0_valid && !wr_rsp0_mdata[MDATA-1]};
        rsp_b   = {wr_rsp1_valid &&  wr_rsp1_mdata[MDATA-1], wr_rsp0_valid &&  wr_rsp0_mdata[MDATA-1]};
        cnt_a_d = next_cnt(cnt_a_q, gnt_a, rsp_a);
        cnt_b_d = next_cnt(cnt_b_q, gnt_b, rsp_b);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
            last_q      <= 1'b1;
            drained_q   <= 1'b1;
            a_rsp_vld_q <= '0;
            b_rsp_vld_q <= '0;
            a_md0_q     <= '0;
            a_md1_q     <= '0;
            b_md0_q     <= '0;
            b_md1_q     <= '0;
        end else begin
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
            if (gnt_a)      last_q <= 1'b0;
            else if (gnt_b) last_q <= 1'b1;
            drained_q   <= (cnt_a_q == '0) && (cnt_b_q == '0) && !a_req_valid && !b_req_valid && !wr_en_q;
            a_rsp_vld_q <= rsp_a;
            b_rsp_vld_q <= rsp_b;
            if (rsp_a[0]) a_md0_q <= wr_rsp0_mdata[MDATA-2:0];
            if (rsp_a[1]) a_md1_q <= wr_rsp1_mdata[MDATA-2:0];
            if (rsp_b[0]) b_md0_q <= wr_rsp0_mdata[MDATA-2:0];
            if (rsp_b[1]) b_md1_q <= wr_rsp1_mdata[MDATA-2:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_mdata_q <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_en_q <= gnt_a || gnt_b;
            if (gnt_a) begin
                wr_addr_q  <= a_req_addr;
                wr_mdata_q <= {1'b0, a_req_mdata};
                wr_data_q  <= a_req_data;
            end else if (gnt_b) begin
                wr_addr_q  <= b_req_addr;
                wr_mdata_q <= {1'b1, b_req_mdata};
                wr_data_q  <= b_req_data;
            end
        end
    end

    assign a_req_ack    = gnt_a;
    assign b_req_ack    = gnt_b;
    assign wr_req_en    = wr_en_q;
    assign wr_req_addr  = wr_addr_q;
    assign wr_req_mdata = wr_mdata_q;
    assign wr_req_data  = wr_data_q;
    assign a_rsp_valid  = a_rsp_vld_q;
    assign b_rsp_valid  = b_rsp_vld_q;
    assign a_rsp_mdata0 = a_md0_q;
    assign a_rsp_mdata1 = a_md1_q;
    assign b_rsp_mdata0 = b_md0_q;
    assign b_rsp_mdata1 = b_md1_q;
    assign drained      = drained_q;

`ifndef SYNTHESIS
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
        (wide_t'(rsp_a[0]) + wide_t'(rsp_a[1])) <= wide_t'(cnt_a_q));
    b_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
        (wide_t'(rsp_b[0]) + wide_t'(rsp_b[1])) <= wide_t'(cnt_b_q));
`endif
endmodule

// File: tb/tb_wr_req_arb.sv
// Bench for wr_req_arb: directed table and sequences plus random traffic against a queue-based reference model.
module tb_wr_req_arb;
    localparam int AW = 20, MW = 14, DW = 512, MO = 4;
    typedef logic [MW-2:0] tag_t;
    typedef logic [AW-1:0] addr_t;

    logic clk = 1'b0, reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          a_v, b_v, af, r0v, r1v;
    logic [AW-1:0] a_addr, b_addr, w_addr;
    tag_t          a_md, b_md, a_rm0, a_rm1, b_rm0, b_rm1;
    logic [DW-1:0] a_dat, b_dat, w_dat;
    logic [MW-1:0] r0m, r1m, w_md;
    logic          a_ack, b_ack, w_en, drn;
    logic [1:0]    a_rv, b_rv;

    wr_req_arb #(.ADDR_LMT(AW), .MDATA(MW), .CACHE_WIDTH(DW), .MAX_OUT(MO)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req_valid(a_v), .a_req_addr(a_addr), .a_req_mdata(a_md), .a_req_data(a_dat),
        .a_req_ack(a_ack), .a_rsp_valid(a_rv), .a_rsp_mdata0(a_rm0), .a_rsp_mdata1(a_rm1),
        .b_req_valid(b_v), .b_req_addr(b_addr), .b_req_mdata(b_md), .b_req_data(b_dat),
        .b_req_ack(b_ack), .b_rsp_valid(b_rv), .b_rsp_mdata0(b_rm0), .b_rsp_mdata1(b_rm1),
        .wr_req_addr(w_addr), .wr_req_mdata(w_md), .wr_req_data(w_dat), .wr_req_en(w_en),
        .wr_req_almostfull(af), .wr_rsp0_valid(r0v), .wr_rsp1_valid(r1v),
        .wr_rsp0_mdata(r0m), .wr_rsp1_mdata(r1m), .drained(drn)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: counters are "writes accepted minus responses returned", floored at zero.
    int            m_cnt[2];
    int            m_last;
    bit            m_en, m_drn;
    logic [AW-1:0] m_addr;
    logic [MW-1:0] m_md;
    logic [DW-1:0] m_dat;
    bit [1:0]      m_rv[2];
    tag_t          m_rm[2][2];
    tag_t          pend_a[$], pend_b[$];

    task automatic model_reset();
        m_cnt[0] = 0; m_cnt[1] = 0; m_last = 1; m_en = 0; m_drn = 1;
        m_addr = '0; m_md = '0; m_dat = '0;
        m_rv[0] = '0; m_rv[1] = '0;
        pend_a.delete(); pend_b.delete();
    endtask

    task automatic check_outputs();
        chk("wr_req_en", 64'(w_en), 64'(m_en));
        chk("wr_req_addr", 64'(w_addr), 64'(m_addr));
        chk("wr_req_mdata", 64'(w_md), 64'(m_md));
        chk("wr_req_data", 64'(w_dat == m_dat), 64'(1));
        chk("a_rsp_valid", 64'(a_rv), 64'(m_rv[0]));
        chk("b_rsp_valid", 64'(b_rv), 64'(m_rv[1]));
        if (m_rv[0][0]) chk("a_rsp_mdata0", 64'(a_rm0), 64'(m_rm[0][0]));
        if (m_rv[0][1]) chk("a_rsp_mdata1", 64'(a_rm1), 64'(m_rm[0][1]));
        if (m_rv[1][0]) chk("b_rsp_mdata0", 64'(b_rm0), 64'(m_rm[1][0]));
        if (m_rv[1][1]) chk("b_rsp_mdata1", 64'(b_rm1), 64'(m_rm[1][1]));
        chk("drained", 64'(drn), 64'(m_drn));
        chk("cnt_a", 64'(dut.cnt_a_q), 64'(m_cnt[0]));
        chk("cnt_b", 64'(dut.cnt_b_q), 64'(m_cnt[1]));
    endtask

    // Called at posedge+1 with inputs set; returns at the next posedge+1 after checking registered outputs.
    task automatic step();
        int win, dec;
        bit ea, eb;
        bit [1:0] rv[2];
        @(negedge clk);
        ea = a_v && (m_cnt[0] < MO) && !af;
        eb = b_v && (m_cnt[1] < MO) && !af;
        win = -1;
        if (ea && eb)  win = (m_last == 0) ? 1 : 0;
        else if (ea)   win = 0;
        else if (eb)   win = 1;
        chk("ack_a", 64'(a_ack), 64'(win == 0));
        chk("ack_b", 64'(b_ack), 64'(win == 1));
        m_drn = (m_cnt[0] == 0) && (m_cnt[1] == 0) && !a_v && !b_v && !m_en;
        m_en  = (win >= 0);
        if (win == 0) begin
            m_addr = a_addr; m_md = {1'b0, a_md}; m_dat = a_dat; pend_a.push_back(a_md);
        end else if (win == 1) begin
            m_addr = b_addr; m_md = {1'b1, b_md}; m_dat = b_dat; pend_b.push_back(b_md);
        end
        if (win >= 0) m_last = win;
        rv[0] = '0; rv[1] = '0;
        if (r0v) begin rv[r0m[MW-1]][0] = 1'b1; m_rm[r0m[MW-1]][0] = r0m[MW-2:0]; end
        if (r1v) begin rv[r1m[MW-1]][1] = 1'b1; m_rm[r1m[MW-1]][1] = r1m[MW-2:0]; end
        for (int x = 0; x < 2; x++) begin
            m_rv[x] = rv[x];
            dec = int'(rv[x][0]) + int'(rv[x][1]);
            m_cnt[x] = m_cnt[x] + int'(win == x) - dec;
            if (m_cnt[x] < 0) m_cnt[x] = 0;
        end
        @(posedge clk); #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        a_v = 0; b_v = 0; af = 0; r0v = 0; r1v = 0; r0m = '0; r1m = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        @(posedge clk); #1;
        chk("rst_en", 64'(w_en), 64'(0));
        chk("rst_drained", 64'(drn), 64'(1));
        chk("rst_rsp", 64'({a_rv, b_rv}), 64'(0));
        chk("rst_cnt", 64'({dut.cnt_a_q, dut.cnt_b_q}), 64'(0));
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit a, b, af, r0, r1;
        logic [MW-1:0] m0, m1;
        bit ea, eb;
    } vec_t;

    function automatic vec_t mk(bit a, bit b, bit f, bit r0, logic [MW-1:0] m0,
                                bit r1, logic [MW-1:0] m1, bit ea, bit eb);
        vec_t v;
        v.a = a; v.b = b; v.af = f; v.r0 = r0; v.m0 = m0; v.r1 = r1; v.m1 = m1; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    vec_t tbl[15];

    initial begin
        int unsigned rsp_odds;
        idle_inputs();
        a_addr = '0; b_addr = '0; a_md = '0; b_md = '0; a_dat = '0; b_dat = '0;

        // Fairness from reset, two drain cycles, then almostfull for four cycles mid-stream.
        for (int i = 0; i < 6; i++) tbl[i] = mk(1, 1, 0, 0, '0, 0, '0, (i % 2) == 0, (i % 2) == 1);
        tbl[6] = mk(0, 0, 0, 1, 14'h0001, 1, 14'h2002, 0, 0);
        tbl[7] = mk(0, 0, 0, 1, 14'h0002, 1, 14'h2003, 0, 0);
        tbl[8] = mk(1, 0, 0, 0, '0, 0, '0, 1, 0);
        for (int i = 9; i < 13; i++) tbl[i] = mk(1, 0, 1, 0, '0, 0, '0, 0, 0);
        tbl[13] = mk(1, 0, 0, 0, '0, 0, '0, 1, 0);
        tbl[14] = mk(0, 0, 0, 0, '0, 0, '0, 0, 0);

        // Single requester: three back-to-back lines.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            a_v = 1; a_addr = addr_t'(32'h10 + i); a_md = tag_t'(5 + i);
            #1 chk("single_ack", 64'(a_ack), 64'(1));
            step();
            chk("single_en", 64'(w_en), 64'(1));
            chk("single_mdata", 64'(w_md), 64'(14'h0005 + i));
            chk("single_addr", 64'(w_addr), 64'(32'h10 + i));
        end
        a_v = 0;
        step();
        chk("single_en_off", 64'(w_en), 64'(0));
        chk("single_addr_hold", 64'(w_addr), 64'(20'h12));
        chk("single_cnt", 64'(dut.cnt_a_q), 64'(3));

        // Table: fairness and back-pressure.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            a_v = tbl[i].a; b_v = tbl[i].b; af = tbl[i].af;
            r0v = tbl[i].r0; r0m = tbl[i].m0; r1v = tbl[i].r1; r1m = tbl[i].m1;
            a_md = tag_t'(i); b_md = tag_t'(32'h100 + i);
            a_addr = addr_t'(i); b_addr = addr_t'(32'h800 + i);
            #1;
            chk("tbl_ack_a", 64'(a_ack), 64'(tbl[i].ea));
            chk("tbl_ack_b", 64'(b_ack), 64'(tbl[i].eb));
            step();
            chk("tbl_issue", 64'(w_en), 64'(tbl[i].ea | tbl[i].eb));
            if (tbl[i].eb)      chk("tbl_b_mdata", 64'(w_md), 64'(14'h2000 | (14'h100 + i)));
            else if (tbl[i].ea) chk("tbl_a_mdata", 64'(w_md), 64'(i));
        end

        // Credit limit: A fills its credits, B keeps flowing, one A response re-enables A a cycle later.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            a_v = 1; b_v = (c >= 4); r0v = (c == 7); r0m = 14'h0009;
            a_md = tag_t'(c); b_md = tag_t'(c);
            #1;
            chk("credit_ack_a", 64'(a_ack), 64'((c < 4) || (c == 8)));
            chk("credit_ack_b", 64'(b_ack), 64'((c >= 4) && (c < 8)));
            step();
        end
        chk("credit_cnt_a", 64'(dut.cnt_a_q), 64'(4));
        chk("credit_cnt_b", 64'(dut.cnt_b_q), 64'(4));

        // Both response lanes returning to A in one cycle.
        do_reset();
        a_v = 1; a_md = tag_t'(3); step();
        a_md = tag_t'(4); step();
        a_v = 0; step();
        r0v = 1; r0m = 14'h0003; r1v = 1; r1m = 14'h0004;
        step();
        chk("dual_valid", 64'(a_rv), 64'(2'b11));
        chk("dual_md0", 64'(a_rm0), 64'(3));
        chk("dual_md1", 64'(a_rm1), 64'(4));
        chk("dual_cnt", 64'(dut.cnt_a_q), 64'(0));
        r0v = 0; r1v = 0;
        step();
        chk("dual_drained", 64'(drn), 64'(1));

        // Asynchronous reset between edges with a write in flight.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a_v = 1; a_md = tag_t'(i); step();
        end
        chk("arst_pre_en", 64'(w_en), 64'(1));
        chk("arst_pre_cnt", 64'(dut.cnt_a_q), 64'(4));
        a_v = 0;
        #1 reset_n = 1'b0;
        #1;
        chk("arst_en", 64'(w_en), 64'(0));
        chk("arst_drained", 64'(drn), 64'(1));
        chk("arst_cnt", 64'(dut.cnt_a_q), 64'(0));
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Random traffic; responses only return writes the model still holds outstanding.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rsp_odds = (c < 300) ? 3 : 1;
            a_v = ($urandom_range(3) != 0); b_v = ($urandom_range(3) != 0);
            af = ($urandom_range(5) == 0);
            a_addr = addr_t'($urandom); b_addr = addr_t'($urandom);
            a_md = tag_t'($urandom); b_md = tag_t'($urandom);
            for (int w = 0; w < DW / 32; w++) begin
                a_dat[w*32 +: 32] = $urandom;
                b_dat[w*32 +: 32] = $urandom;
            end
            r0v = 0; r1v = 0;
            if ($urandom_range(rsp_odds) == 0) begin
                if ($urandom_range(1) == 0 && pend_a.size() > 0) begin r0v = 1; r0m = {1'b0, pend_a.pop_front()}; end
                else if (pend_b.size() > 0)                       begin r0v = 1; r0m = {1'b1, pend_b.pop_front()}; end
            end
            if ($urandom_range(rsp_odds) == 0) begin
                if ($urandom_range(1) == 0 && pend_a.size() > 0) begin r1v = 1; r1m = {1'b0, pend_a.pop_front()}; end
                else if (pend_b.size() > 0)                       begin r1v = 1; r1m = {1'b1, pend_b.pop_front()}; end
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
